csr_commit_file: RTL and testbench
==================================

# csr_commit_file

Architectural control/status register file on the receiving end of the Ctrl_ALU CSR write port. It accepts one speculative CSR write from execute and holds it until retirement, where it either commits or is discarded on flush. It also maintains the cycle/time/instret counters and FP flags/rounding mode. It feeds CSR read data back to register-read as data2 for CSR instructions.

## Interface
- CSR_DATA_W, 64, CSR data width (matches `CSR_WIDTH)
- CSR_ADDR_W, 12, CSR address width (matches `CSR_WIDTH_LOG)
- TIME_DIV, 16, cycles per time-counter tick (>=1)
- clk  in  1  clock; one clock domain
- reset  in  1  synchronous, active-high reset
- csrWrEn_i  in  1  execute-side write request
- csrWrAddr_i  in  CSR_ADDR_W  write address
- csrWrData_i  in  CSR_DATA_W  write data (already merged for set/clear)
- csrCommit_i  in  1  retire pulse for the CSR instruction owning the pending write
- flush_i  in  1  pipeline flush; discards pending write
- commitCount_i  in  3  instructions retired this cycle, 0..4
- fpFlagsValid_i  in  1  retiring FP ops carry flags
- fpFlags_i  in  5  accrued exception flags (NV,DZ,OF,UF,NX)
- csrRdAddr_i  in  CSR_ADDR_W  read address
- csrRdData_o  out  CSR_DATA_W  combinational architectural read data
- frm_o  out  3  current rounding mode
- csrPending_o  out  1  pending write buffer occupied
- csrIllegal_o  out  1  one-cycle pulse: committed write hit read-only/unimplemented address

## Operation
- Address map: fflags 0x001 (5b), frm 0x002 (3b), fcsr 0x003 ({frm,fflags}, 8b), cycle 0xC00, time 0xC01, instret 0xC02 (read-only, 64b), mscratch 0x340 (see Configuration). Other addresses unimplemented: read 0.
- Pending buffer, states EMPTY/HELD: EMPTY + csrWrEn_i & !flush_i -> HELD, latch addr/data. HELD + csrCommit_i -> apply write, EMPTY. HELD + flush_i (no commit) -> EMPTY, write discarded.
- csrWrEn_i while HELD: ignored (no overwrite); front end serialises CSR instructions, violation is a protocol error flagged by assertion.
- Commit to read-only/unimplemented address: no state change, csrIllegal_o=1 next cycle.
- Writes zero-extend/truncate: fflags takes data[4:0], frm data[2:0], fcsr splits data[7:5]->frm, data[4:0]->fflags; upper bits read as 0.
- cycle += 1 every cycle; instret += commitCount_i; prescaler counts 0..TIME_DIV-1, time += 1 on wrap. All 64b, wrap to 0 at 2^64.
- fflags accumulation: fflags |= fpFlags_i when fpFlagsValid_i.
- Reads return architectural state only; pending data never bypassed.

## Timing
- Reset: all CSRs, counters, prescaler = 0; buffer EMPTY; csrPending_o=0, csrIllegal_o=0, frm_o=0, csrRdData_o reflects zeros.
- Request captured at clk edge; csrPending_o high the following cycle.
- Committed write visible on csrRdData_o/frm_o the cycle after csrCommit_i.
- csrCommit_i and flush_i same cycle: commit wins (CSR is oldest), then EMPTY; same-cycle csrWrEn_i dropped.
- csrCommit_i while EMPTY: no effect.
- Same-cycle fflags write commit and fpFlagsValid_i: result = written value | fpFlags_i.
- Counters read as pre-increment value of current cycle; counters unaffected by flush.
- reset mid-operation overrides all: pending write lost, counters zeroed.

## Configuration
- CSR_SCRATCH_EN defined: mscratch (0x340, 64b read/write) implemented, reset 0.
- Undefined: 0x340 unimplemented; reads 0, committed writes raise csrIllegal_o.

## Test plan
- Reset, then idle 20 cycles with TIME_DIV=16 -> cycle reads 20, time reads 1, instret 0.
- Write fcsr=0xE5, commit -> next cycle fcsr reads 0xE5, frm_o=7, fflags reads 0x05.
- Write frm=3, flush_i before commit -> frm_o stays 0, csrPending_o clears, no illegal pulse.
- Commit write to cycle (0xC00) data 0x1234 -> csrIllegal_o pulses once, cycle keeps counting.
- Same cycle: commit fflags=0x01 with fpFlagsValid_i=1, fpFlags_i=0x10 -> fflags reads 0x11.
- commitCount_i=4 for 3 cycles then 2 -> instret reads 14; with CSR_SCRATCH_EN write mscratch=0xDEAD_BEEF reads back, without it reads 0 and illegal pulses.

Source files
------------

// File: rtl/csr_commit_file.sv
// csr_commit_file
//   Architectural CSR file behind the execute-side CSR write port. One
//   speculative write is parked in a pending buffer until its instruction
//   retires (commit) or the pipeline flushes. It also keeps the
//   cycle/time/instret counters and the FP flags/rounding-mode state.
//
//   Optional feature macro: CSR_SCRATCH_EN. When it is defined, mscratch
//   (0x340) is implemented. When it is not defined, 0x340 is unimplemented.
//
// Ports
//   clk, reset      : single clock; synchronous active-high reset
//   csrWrEn_i       : write request from execute (address and data in the same cycle)
//   csrWrAddr_i     : write address
//   csrWrData_i     : write data, already merged for set/clear
//   csrCommit_i     : retire pulse for the owner of the pending write
//   flush_i         : discards the pending write
//   commitCount_i   : instructions retired this cycle (0..4)
//   fpFlagsValid_i  : fpFlags_i is valid this cycle
//   fpFlags_i       : accrued FP exception flags {NV,DZ,OF,UF,NX}
//   csrRdAddr_i     : read address
//   csrRdData_o     : combinational read of architectural state
//   frm_o           : current rounding mode
//   csrPending_o    : pending buffer holds a write
//   csrIllegal_o    : one-cycle pulse after a committed write to a RO/unimplemented address
module csr_commit_file #(
  parameter int CSR_DATA_W = 64,
  parameter int CSR_ADDR_W = 12,
  parameter int TIME_DIV   = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  csrWrEn_i,
  input  logic [CSR_ADDR_W-1:0] csrWrAddr_i,
  input  logic [CSR_DATA_W-1:0] csrWrData_i,
  input  logic                  csrCommit_i,
  input  logic                  flush_i,
  input  logic [2:0]            commitCount_i,
  input  logic                  fpFlagsValid_i,
  input  logic [4:0]            fpFlags_i,
  input  logic [CSR_ADDR_W-1:0] csrRdAddr_i,
  output logic [CSR_DATA_W-1:0] csrRdData_o,
  output logic [2:0]            frm_o,
  output logic                  csrPending_o,
  output logic                  csrIllegal_o
);

  localparam logic [CSR_ADDR_W-1:0] A_FFLAGS  = CSR_ADDR_W'('h001);
  localparam logic [CSR_ADDR_W-1:0] A_FRM     = CSR_ADDR_W'('h002);
  localparam logic [CSR_ADDR_W-1:0] A_FCSR    = CSR_ADDR_W'('h003);
  localparam logic [CSR_ADDR_W-1:0] A_SCRATCH = CSR_ADDR_W'('h340);
  localparam logic [CSR_ADDR_W-1:0] A_CYCLE   = CSR_ADDR_W'('hC00);
  localparam logic [CSR_ADDR_W-1:0] A_TIME    = CSR_ADDR_W'('hC01);
  localparam logic [CSR_ADDR_W-1:0] A_INSTRET = CSR_ADDR_W'('hC02);

  // The prescaler needs at least one bit, even when TIME_DIV is 1.
  localparam int PW = (TIME_DIV > 1) ? $clog2(TIME_DIV) : 1;

  typedef enum logic {EMPTY = 1'b0, HELD = 1'b1} pend_state_e;

  pend_state_e           state_q,   state_d;
  logic [CSR_ADDR_W-1:0] addr_q,    addr_d;
  logic [CSR_DATA_W-1:0] data_q,    data_d;
  logic [4:0]            fflags_q,  fflags_d;
  logic [2:0]            frm_q,     frm_d;
  logic [CSR_DATA_W-1:0] cycle_q,   cycle_d;
  logic [CSR_DATA_W-1:0] time_q,    time_d;
  logic [CSR_DATA_W-1:0] instret_q, instret_d;
  logic [PW-1:0]         presc_q,   presc_d;
  logic                  illegal_q, illegal_d;
  logic                  write_fire;
`ifdef CSR_SCRATCH_EN
  logic [CSR_DATA_W-1:0] scratch_q, scratch_d;
`else
  // Only the low byte of a parked write can reach architectural state.
  logic                  unused_data_hi;
  assign unused_data_hi = ^data_q[CSR_DATA_W-1:8];
`endif

  assign write_fire = (state_q == HELD) && csrCommit_i;

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    data_d    = data_q;
    fflags_d  = fflags_q;
    frm_d     = frm_q;
    illegal_d = 1'b0;
    cycle_d   = cycle_q + 1'b1;
    instret_d = instret_q + CSR_DATA_W'(commitCount_i);
    time_d    = time_q;
    presc_d   = presc_q + 1'b1;
`ifdef CSR_SCRATCH_EN
    scratch_d = scratch_q;
`endif

    if (presc_q == PW'(TIME_DIV - 1)) begin
      presc_d = '0;
      time_d  = time_q + 1'b1;
    end

    // A new request is taken only while the buffer is empty. Commit takes
    // priority over flush because the CSR instruction is the oldest one.
    case (state_q)
      EMPTY: if (csrWrEn_i && !flush_i) begin
        state_d = HELD;
        addr_d  = csrWrAddr_i;
        data_d  = csrWrData_i;
      end
      HELD: if (csrCommit_i || flush_i) state_d = EMPTY;
      default: state_d = EMPTY;
    endcase

    if (write_fire) begin
      case (addr_q)
        A_FFLAGS: fflags_d = data_q[4:0];
        A_FRM:    frm_d    = data_q[2:0];
        A_FCSR: begin
          frm_d    = data_q[7:5];
          fflags_d = data_q[4:0];
        end
`ifdef CSR_SCRATCH_EN
        A_SCRATCH: scratch_d = data_q;
`endif
        default: illegal_d = 1'b1;
      endcase
    end

    // Flags accrued in the same cycle are ORed on top of a committed write.
    if (fpFlagsValid_i) fflags_d = fflags_d | fpFlags_i;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= EMPTY;
      addr_q    <= '0;
      data_q    <= '0;
      fflags_q  <= '0;
      frm_q     <= '0;
      cycle_q   <= '0;
      time_q    <= '0;
      instret_q <= '0;
      presc_q   <= '0;
      illegal_q <= 1'b0;
`ifdef CSR_SCRATCH_EN
      scratch_q <= '0;
`endif
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      fflags_q  <= fflags_d;
      frm_q     <= frm_d;
      cycle_q   <= cycle_d;
      time_q    <= time_d;
      instret_q <= instret_d;
      presc_q   <= presc_d;
      illegal_q <= illegal_d;
`ifdef CSR_SCRATCH_EN
      scratch_q <= scratch_d;
`endif
    end
  end

  // Reads see architectural state only; a parked write is never bypassed.
  always_comb begin
    csrRdData_o = '0;
    case (csrRdAddr_i)
      A_FFLAGS:  csrRdData_o = CSR_DATA_W'(fflags_q);
      A_FRM:     csrRdData_o = CSR_DATA_W'(frm_q);
      A_FCSR:    csrRdData_o = CSR_DATA_W'({frm_q, fflags_q});
      A_CYCLE:   csrRdData_o = cycle_q;
      A_TIME:    csrRdData_o = time_q;
      A_INSTRET: csrRdData_o = instret_q;
`ifdef CSR_SCRATCH_EN
      A_SCRATCH: csrRdData_o = scratch_q;
`endif
      default:   csrRdData_o = '0;
    endcase
  end

  assign frm_o        = frm_q;
  assign csrPending_o = (state_q == HELD);
  assign csrIllegal_o = illegal_q;

  // The front end serialises CSR instructions. A second request while a
  // write is parked, and not being retired or flushed, is a protocol error.
  a_no_overwrite: assert property (@(posedge clk) disable iff (reset)
    !((state_q == HELD) && csrWrEn_i && !csrCommit_i && !flush_i));

endmodule

// File: tb/tb_csr_commit_file.sv
module tb_csr_commit_file;
  localparam int DW = 64;
  localparam int AW = 12;
  localparam int TD = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          csrWrEn_i, csrCommit_i, flush_i, fpFlagsValid_i;
  logic [AW-1:0] csrWrAddr_i, csrRdAddr_i;
  logic [DW-1:0] csrWrData_i;
  logic [2:0]    commitCount_i;
  logic [4:0]    fpFlags_i;
  logic [DW-1:0] csrRdData_o;
  logic [2:0]    frm_o;
  logic          csrPending_o, csrIllegal_o;

  always #5 clk = ~clk;

  csr_commit_file #(.CSR_DATA_W(DW), .CSR_ADDR_W(AW), .TIME_DIV(TD)) dut (
    .clk(clk), .reset(reset),
    .csrWrEn_i(csrWrEn_i), .csrWrAddr_i(csrWrAddr_i), .csrWrData_i(csrWrData_i),
    .csrCommit_i(csrCommit_i), .flush_i(flush_i), .commitCount_i(commitCount_i),
    .fpFlagsValid_i(fpFlagsValid_i), .fpFlags_i(fpFlags_i),
    .csrRdAddr_i(csrRdAddr_i), .csrRdData_o(csrRdData_o), .frm_o(frm_o),
    .csrPending_o(csrPending_o), .csrIllegal_o(csrIllegal_o));

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model. Elapsed cycles are counted directly. Time is derived
  // as elapsed/TD. The pending write is a single optional record.
  logic [DW-1:0] m_cyc, m_inst, m_scr, m_d;
  logic [4:0]    m_ff;
  logic [2:0]    m_frm;
  logic [AW-1:0] m_a;
  bit            m_held, m_ill, m_live = 1'b0;

  function automatic logic [DW-1:0] m_read(input logic [AW-1:0] a);
    case (a)
      12'h001: return DW'(m_ff);
      12'h002: return DW'(m_frm);
      12'h003: return DW'({m_frm, m_ff});
      12'hC00: return m_cyc;
      12'hC01: return m_cyc / TD;
      12'hC02: return m_inst;
`ifdef CSR_SCRATCH_EN
      12'h340: return m_scr;
`endif
      default: return '0;
    endcase
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_cyc = '0; m_inst = '0; m_scr = '0; m_ff = '0; m_frm = '0;
      m_held = 1'b0; m_ill = 1'b0; m_live = 1'b1;
    end else begin
      m_ill = 1'b0;
      if (m_held && csrCommit_i) begin
        m_held = 1'b0;
        if (m_a == 12'h001) m_ff = m_d[4:0];
        else if (m_a == 12'h002) m_frm = m_d[2:0];
        else if (m_a == 12'h003) begin m_frm = m_d[7:5]; m_ff = m_d[4:0]; end
`ifdef CSR_SCRATCH_EN
        else if (m_a == 12'h340) m_scr = m_d;
`endif
        else m_ill = 1'b1;
      end else if (m_held && flush_i) begin
        m_held = 1'b0;
      end else if (!m_held && csrWrEn_i && !flush_i) begin
        m_held = 1'b1; m_a = csrWrAddr_i; m_d = csrWrData_i;
      end
      if (fpFlagsValid_i) m_ff = m_ff | fpFlags_i;
      m_cyc  = m_cyc + 1;
      m_inst = m_inst + DW'(commitCount_i);
    end
  end

  always @(negedge clk) begin
    if (m_live) begin
      chk("rdata",   csrRdData_o,       m_read(csrRdAddr_i));
      chk("frm",     DW'(frm_o),        DW'(m_frm));
      chk("pending", DW'(csrPending_o), DW'(m_held));
      chk("illegal", DW'(csrIllegal_o), DW'(m_ill));
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic lit(input string name, input logic [AW-1:0] a, input logic [DW-1:0] e);
    csrRdAddr_i = a;
    #1;
    chk(name, csrRdData_o, e);
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    csrWrEn_i = 1'b1; csrWrAddr_i = a; csrWrData_i = d;
    tick(1);
    csrWrEn_i = 1'b0;
    chk("pend_set", DW'(csrPending_o), 64'd1);
  endtask

  logic [AW-1:0] sweep [8] = '{12'h001, 12'h002, 12'h003, 12'hC00, 12'hC01, 12'hC02, 12'h340, 12'h7FF};

  initial begin
    reset = 1'b1; csrWrEn_i = 0; csrCommit_i = 0; flush_i = 0; fpFlagsValid_i = 0;
    csrWrAddr_i = '0; csrWrData_i = '0; commitCount_i = '0; fpFlags_i = '0; csrRdAddr_i = '0;
    tick(3);
    lit("rst_cycle", 12'hC00, 64'd0);
    lit("rst_fcsr", 12'h003, 64'd0);
    chk("rst_pend", DW'(csrPending_o), 64'd0);

    // idle counters
    reset = 1'b0;
    tick(20);
    lit("idle_cycle", 12'hC00, 64'd20);
    lit("idle_time", 12'hC01, 64'd1);
    lit("idle_instret", 12'hC02, 64'd0);

    // flushed frm write is discarded
    wr(12'h002, 64'd3);
    flush_i = 1'b1; tick(1); flush_i = 1'b0;
    chk("flush_frm", DW'(frm_o), 64'd0);
    chk("flush_pend", DW'(csrPending_o), 64'd0);
    chk("flush_ill", DW'(csrIllegal_o), 64'd0);

    // fcsr write and commit
    wr(12'h003, 64'hE5);
    csrCommit_i = 1'b1; tick(1); csrCommit_i = 1'b0;
    lit("fcsr_rd", 12'h003, 64'hE5);
    chk("fcsr_frm", DW'(frm_o), 64'd7);
    lit("fcsr_fflags", 12'h001, 64'h05);

    // write to read-only cycle counter
    wr(12'hC00, 64'h1234);
    csrCommit_i = 1'b1; tick(1); csrCommit_i = 1'b0;
    chk("ro_ill_hi", DW'(csrIllegal_o), 64'd1);
    tick(1);
    chk("ro_ill_lo", DW'(csrIllegal_o), 64'd0);

    // read sweep, checked each cycle by the compare process
    for (int i = 0; i < 8; i++) begin csrRdAddr_i = sweep[i]; tick(1); end

    // same-cycle fflags commit and accrued flags
    wr(12'h001, 64'h01);
    csrCommit_i = 1'b1; fpFlagsValid_i = 1'b1; fpFlags_i = 5'h10;
    tick(1);
    csrCommit_i = 1'b0; fpFlagsValid_i = 1'b0; fpFlags_i = '0;
    lit("ff_merge", 12'h001, 64'h11);

    // instret accumulation
    commitCount_i = 3'd4; tick(3);
    commitCount_i = 3'd2; tick(1);
    commitCount_i = 3'd0;
    lit("instret14", 12'hC02, 64'd14);

    // mscratch
    wr(12'h340, 64'hDEAD_BEEF);
    csrCommit_i = 1'b1; tick(1); csrCommit_i = 1'b0;
`ifdef CSR_SCRATCH_EN
    lit("scr_rd", 12'h340, 64'hDEAD_BEEF);
    chk("scr_ill", DW'(csrIllegal_o), 64'd0);
`else
    lit("scr_rd", 12'h340, 64'd0);
    chk("scr_ill", DW'(csrIllegal_o), 64'd1);
`endif

    // commit with an empty buffer does nothing
    csrCommit_i = 1'b1; tick(1); csrCommit_i = 1'b0;
    chk("empty_commit_ill", DW'(csrIllegal_o), 64'd0);

    // commit beats flush; same-cycle request is dropped
    wr(12'h002, 64'd5);
    csrCommit_i = 1'b1; flush_i = 1'b1;
    csrWrEn_i = 1'b1; csrWrAddr_i = 12'h002; csrWrData_i = 64'd6;
    tick(1);
    csrCommit_i = 1'b0; flush_i = 1'b0; csrWrEn_i = 1'b0;
    chk("cf_frm", DW'(frm_o), 64'd5);
    chk("cf_pend", DW'(csrPending_o), 64'd0);

    // a request that arrives together with a flush is not captured
    csrWrEn_i = 1'b1; csrWrAddr_i = 12'h001; flush_i = 1'b1;
    tick(1);
    csrWrEn_i = 1'b0; flush_i = 1'b0;
    chk("wf_pend", DW'(csrPending_o), 64'd0);

    // flag accrual without a write
    fpFlagsValid_i = 1'b1; fpFlags_i = 5'h04; tick(1); fpFlagsValid_i = 1'b0;
    lit("ff_accrue", 12'h001, 64'h15);

    // reset during a pending write
    wr(12'h002, 64'd1);
    reset = 1'b1; tick(1);
    chk("mr_pend", DW'(csrPending_o), 64'd0);
    lit("mr_cycle", 12'hC00, 64'd0);
    reset = 1'b0; tick(1);
    lit("mr_cycle1", 12'hC00, 64'd1);
    chk("mr_frm", DW'(frm_o), 64'd0);

    tick(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
